// File: rtl/fano_sync_pkg.sv
// Shared constants for the request/acknowledge synchroniser wrapper:
// FSM state encoding and default parameter values.
package fano_sync_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam int DEF_CNT_W   = 4;
  localparam int DEF_TMO_W   = 16;
  localparam int DEF_TMO_VAL = 50000;
endpackage

// File: rtl/sync_req_ctrl_if.sv
// Control bundle between the synchroniser/decoder wrapper and sync_req_ctrl.
interface sync_req_ctrl_if
  import fano_sync_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             i_req_tgl;
  logic             i_done;
  logic             i_clr;
  logic             o_start;
  logic             o_ack_tgl;
  logic [CNT_W-1:0] o_pending;
  logic             o_overflow;
  logic             o_timeout;

  modport master (
    output i_req_tgl, i_done, i_clr,
    input  o_start, o_ack_tgl, o_pending, o_overflow, o_timeout
  );

  modport slave (
    input  i_req_tgl, i_done, i_clr,
    output o_start, o_ack_tgl, o_pending, o_overflow, o_timeout
  );
endinterface

// File: rtl/sync_req_ctrl_tgl_edge_det.sv
// Toggle-to-event converter. The first clock after reset only captures the
// input level, so a toggle line that is already high never fakes an event.
module tgl_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tgl,
  output logic o_event
);
  logic req_d_q, req_d_d;
  logic primed_q, primed_d;

  always_comb begin
    req_d_d  = i_tgl;
    primed_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_d_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      req_d_q  <= req_d_d;
      primed_q <= primed_d;
    end
  end

  assign o_event = primed_q & (i_tgl ^ req_d_q);
endmodule

// File: rtl/sync_req_ctrl.sv
// Destination-domain request controller: queues toggle requests, issues
// decoder start pulses, waits for done/timeout and returns a toggle ack.
module sync_req_ctrl
  import fano_sync_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO_W   = DEF_TMO_W,
  parameter int TMO_VAL = DEF_TMO_VAL
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  sync_req_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_VAL - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             ovf_q, ovf_d, ovf_set;
  logic             start_q, start_d;
  logic             timeout_q, timeout_d;
  logic             ack_q, ack_d;
  logic             evt, dec;

  tgl_edge_det u_req_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tgl   (bus.i_req_tgl),
    .o_event (evt)
  );

  assign dec = (state_q == ST_IDLE) && (pending_q != '0);

  // Simultaneous enqueue and dequeue cancel; a full queue drops the event.
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (evt && !dec) begin
      if (pending_q == CNT_MAX) ovf_set = 1'b1;
      else                      pending_d = pending_q + 1'b1;
    end else if (!evt && dec) begin
      pending_d = pending_q - 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~bus.i_clr);
  end

  // Pulse outputs are registered alongside the state they belong to.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    ack_d     = ack_q;
    case (state_q)
      ST_IDLE: if (dec) begin
        state_d = ST_START;
        start_d = 1'b1;
      end
      ST_START: begin
        state_d   = ST_RUN;
        tmo_cnt_d = '0;
      end
      ST_RUN: begin
        if (bus.i_done) begin
          state_d = ST_ACK;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_ACK;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ack_d   = ~ack_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      tmo_cnt_q <= '0;
      ovf_q     <= 1'b0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tmo_cnt_q <= tmo_cnt_d;
      ovf_q     <= ovf_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.o_start    = start_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_ack_tgl  = ack_q;
  assign bus.o_pending  = pending_q;
  assign bus.o_overflow = ovf_q;
endmodule
